param_buffer_ctrl: RTL and testbench

- Parametrised, multi-bank parameter buffer controller for the EPU.
- Owns the on-chip parameter storage, NUM_BANKS banks of DEPTH words each.
- Arbitrates between host-side burst access (from the EPU AXI wrapper) and direct EPU single-word access.
- Adds over the previous generation: configurable width, depth and bank count; multi-beat bursts with backpressure; explicit ownership handover.

---
 rtl/param_buffer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_param_buffer_ctrl.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_buffer_ctrl.sv
// Parameter buffer controller: NUM_BANKS x DEPTH words shared between host bursts and EPU access.
// Optional byte-strobe writes are enabled by defining PARAM_BUF_WSTRB_EN.
module param_buffer_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned AW        = $clog2(NUM_BANKS * DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hcmd_valid,
    output logic                hcmd_ready,
    input  logic                hcmd_write,
    input  logic [AW-1:0]       hcmd_addr,
    input  logic [7:0]          hcmd_len,
    input  logic                hw_valid,
    input  logic [DATA_W-1:0]   hw_data,
`ifdef PARAM_BUF_WSTRB_EN
    input  logic [DATA_W/8-1:0] hw_strb,
    input  logic [DATA_W/8-1:0] epu_wstrb,
`endif
    output logic                hw_ready,
    output logic                hr_valid,
    output logic [DATA_W-1:0]   hr_data,
    output logic                hr_last,
    input  logic                hr_ready,
    input  logic                epu_start,
    input  logic                epu_finish,
    output logic                epu_busy,
    input  logic                epu_cs,
    input  logic                epu_we,
    input  logic [AW-1:0]       epu_addr,
    input  logic [DATA_W-1:0]   epu_wdata,
    output logic [DATA_W-1:0]   epu_rdata
);

    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned WORDS = NUM_BANKS * DEPTH;

    typedef enum logic [1:0] {StIdle, StEpuOwn, StHRd, StHWr} state_e;

    state_e            state_q;
    logic [AW-1:0]     addr_q;
    logic [7:0]        len_q;
    logic [8:0]        beat_q;
    logic              hw_ready_q, hr_valid_q, hr_last_q, epu_busy_q;
    logic [DATA_W-1:0] hr_data_q, epu_rdata_q;
    logic [DATA_W-1:0] mem [WORDS];

    logic              hw_beat, epu_wr, epu_rd, rd_issue;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata, mem_wmask;

    // hcmd_ready is held low during reset so a command can never be half-accepted.
    assign hcmd_ready = rst && (state_q == StIdle) && !epu_start;
    assign hw_beat    = (state_q == StHWr) && hw_ready_q && hw_valid;
    assign epu_wr     = (state_q == StEpuOwn) && epu_cs && epu_we;
    assign epu_rd     = (state_q == StEpuOwn) && epu_cs && !epu_we;
    assign rd_issue   = (state_q == StHRd) && (beat_q <= {1'b0, len_q})
                        && (!hr_valid_q || hr_ready);

    assign hw_ready  = hw_ready_q;
    assign hr_valid  = hr_valid_q;
    assign hr_data   = hr_data_q;
    assign hr_last   = hr_last_q;
    assign epu_busy  = epu_busy_q;
    assign epu_rdata = epu_rdata_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = hw_data;
        mem_wmask = '1;
        if (hw_beat) begin
            mem_we = 1'b1;
`ifdef PARAM_BUF_WSTRB_EN
            for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                mem_wmask[b*8 +: 8] = {8{hw_strb[b]}};
            end
`endif
        end else if (epu_wr) begin
            mem_we    = 1'b1;
            mem_waddr = epu_addr;
            mem_wdata = epu_wdata;
`ifdef PARAM_BUF_WSTRB_EN
            for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                mem_wmask[b*8 +: 8] = {8{epu_wstrb[b]}};
            end
`endif
        end
    end

    // Storage is deliberately not cleared by reset; writes are only blocked while it is held.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            hw_ready_q  <= 1'b0;
            hr_valid_q  <= 1'b0;
            hr_last_q   <= 1'b0;
            epu_busy_q  <= 1'b0;
            hr_data_q   <= '0;
            epu_rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    epu_rdata_q <= '0;
                    if (epu_start) begin
                        state_q    <= StEpuOwn;
                        epu_busy_q <= 1'b1;
                    end else if (hcmd_valid) begin
                        addr_q <= hcmd_addr;
                        len_q  <= hcmd_len;
                        beat_q <= '0;
                        if (hcmd_write) begin
                            state_q    <= StHWr;
                            hw_ready_q <= 1'b1;
                        end else begin
                            state_q <= StHRd;
                        end
                    end
                end
                StEpuOwn: begin
                    if (epu_rd) begin
                        epu_rdata_q <= mem[epu_addr];
                    end else if (epu_finish) begin
                        epu_rdata_q <= '0;
                    end
                    if (epu_finish) begin
                        state_q    <= StIdle;
                        epu_busy_q <= 1'b0;
                    end
                end
                StHWr: begin
                    if (hw_beat) begin
                        // Index wraps inside the bank; the bank bits never change.
                        addr_q[IW-1:0] <= addr_q[IW-1:0] + 1'b1;
                        beat_q         <= beat_q + 9'd1;
                        if (beat_q == {1'b0, len_q}) begin
                            state_q    <= StIdle;
                            hw_ready_q <= 1'b0;
                        end
                    end
                end
                StHRd: begin
                    if (rd_issue) begin
                        hr_data_q      <= mem[addr_q];
                        hr_valid_q     <= 1'b1;
                        hr_last_q      <= (beat_q == {1'b0, len_q});
                        addr_q[IW-1:0] <= addr_q[IW-1:0] + 1'b1;
                        beat_q         <= beat_q + 9'd1;
                    end else if (hr_valid_q && hr_ready) begin
                        hr_valid_q <= 1'b0;
                        hr_last_q  <= 1'b0;
                        if (hr_last_q) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_param_buffer_ctrl.sv
// Bench for param_buffer_ctrl: directed scenarios plus randomized traffic against a word-array model.
module tb_param_buffer_ctrl;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int NUM_BANKS = 2;
    localparam int AW        = 5;
    localparam int WORDS     = NUM_BANKS * DEPTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              hcmd_valid, hcmd_ready, hcmd_write;
    logic [AW-1:0]     hcmd_addr;
    logic [7:0]        hcmd_len;
    logic              hw_valid, hw_ready;
    logic [DATA_W-1:0] hw_data;
    logic              hr_valid, hr_last, hr_ready;
    logic [DATA_W-1:0] hr_data;
    logic              epu_start, epu_finish, epu_busy, epu_cs, epu_we;
    logic [AW-1:0]     epu_addr;
    logic [DATA_W-1:0] epu_wdata, epu_rdata;
`ifdef PARAM_BUF_WSTRB_EN
    logic [3:0]        hw_strb, epu_wstrb;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [WORDS];
    logic [31:0] wq[$];
    bit          rdy_q[$];
    logic [31:0] got_d[$];
    bit          got_l[$];
    int          stall_bad;

    always #5 clk = ~clk;

    param_buffer_ctrl #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NUM_BANKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hcmd_valid (hcmd_valid),
        .hcmd_ready (hcmd_ready),
        .hcmd_write (hcmd_write),
        .hcmd_addr  (hcmd_addr),
        .hcmd_len   (hcmd_len),
        .hw_valid   (hw_valid),
        .hw_data    (hw_data),
`ifdef PARAM_BUF_WSTRB_EN
        .hw_strb    (hw_strb),
        .epu_wstrb  (epu_wstrb),
`endif
        .hw_ready   (hw_ready),
        .hr_valid   (hr_valid),
        .hr_data    (hr_data),
        .hr_last    (hr_last),
        .hr_ready   (hr_ready),
        .epu_start  (epu_start),
        .epu_finish (epu_finish),
        .epu_busy   (epu_busy),
        .epu_cs     (epu_cs),
        .epu_we     (epu_we),
        .epu_addr   (epu_addr),
        .epu_wdata  (epu_wdata),
        .epu_rdata  (epu_rdata)
    );

    // Word address of beat i of a burst starting at a: index wraps, bank fixed.
    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a, input int i);
        logic [3:0] ix;
        ix = 4'((int'(a[3:0]) + i) % DEPTH);
        return {a[4], ix};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] len, input int vpct,
                              input bit rnd_strb, output int busy_ready, output int cyc_used);
        int n;
        int guard;
        bit acc;
        bit fire;
        logic [3:0] s;
        hcmd_valid = 1'b1; hcmd_write = 1'b1; hcmd_addr = a; hcmd_len = len;
        acc = 1'b0; guard = 0; busy_ready = 0; cyc_used = 0;
        while (!acc && guard < 100) begin
            @(negedge clk); acc = hcmd_ready;
            @(posedge clk); #1; guard++;
        end
        hcmd_valid = 1'b0;
        if (!acc) begin
            errors++; checks++;
            $display("FAIL host_write_accept: hcmd_ready stayed 0, required 1");
            return;
        end
        n = 0; guard = 0;
        while (n <= int'(len) && guard < 5000) begin
            hw_valid = ($urandom_range(99) < vpct);
            hw_data  = (n < wq.size()) ? wq[n] : $urandom;
            s = 4'hF;
`ifdef PARAM_BUF_WSTRB_EN
            if (rnd_strb) s = 4'($urandom);
            hw_strb = s;
`else
            if (rnd_strb) s = 4'hF;
`endif
            @(negedge clk);
            fire = hw_valid && hw_ready;
            if (hcmd_ready) busy_ready++;
            @(posedge clk); #1; guard++;
            if (fire) begin
                model_mem[wrap_addr(a, n)] = merge(model_mem[wrap_addr(a, n)], hw_data, s);
                n++;
            end
        end
        hw_valid = 1'b0;
        cyc_used = guard;
        if (n <= int'(len)) begin
            errors++; checks++;
            $display("FAIL host_write_beats: accepted %0d beats, required %0d", n, len + 1);
        end
    endtask

    task automatic host_read(input logic [AW-1:0] a, input logic [7:0] len, input int rpct);
        int guard;
        bit acc;
        bit done;
        bit have_stall;
        logic [31:0] stall_d;
        logic stall_l;
        hcmd_valid = 1'b1; hcmd_write = 1'b0; hcmd_addr = a; hcmd_len = len;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 100) begin
            @(negedge clk); acc = hcmd_ready;
            @(posedge clk); #1; guard++;
        end
        hcmd_valid = 1'b0;
        got_d.delete(); got_l.delete(); stall_bad = 0;
        if (!acc) begin
            errors++; checks++;
            $display("FAIL host_read_accept: hcmd_ready stayed 0, required 1");
            return;
        end
        done = 1'b0; have_stall = 1'b0; guard = 0; stall_d = '0; stall_l = 1'b0;
        while (!done && guard < 5000) begin
            if (rdy_q.size() > 0) hr_ready = rdy_q.pop_front();
            else hr_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (have_stall && (!hr_valid || hr_data !== stall_d || hr_last !== stall_l))
                stall_bad++;
            have_stall = hr_valid && !hr_ready;
            stall_d = hr_data; stall_l = hr_last;
            if (hr_valid && hr_ready) begin
                got_d.push_back(hr_data);
                got_l.push_back(hr_last);
                if (hr_last) done = 1'b1;
            end
            @(posedge clk); #1; guard++;
        end
        hr_ready = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL host_read_last: no final beat after %0d cycles, required one", guard);
        end
    endtask

    task automatic epu_acquire();
        int guard;
        epu_start = 1'b1; guard = 0;
        while (epu_busy !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        epu_start = 1'b0;
        checks++;
        if (epu_busy !== 1'b1) begin
            errors++;
            $display("FAIL epu_acquire: epu_busy=%b, required 1", epu_busy);
        end
    endtask

    task automatic test_reset();
        int br;
        int cu;
        rst = 1'b0;
        hcmd_valid = 0; hcmd_write = 0; hcmd_addr = '0; hcmd_len = '0;
        hw_valid = 0; hw_data = '0; hr_ready = 0;
        epu_start = 0; epu_finish = 0; epu_cs = 0; epu_we = 0; epu_addr = '0; epu_wdata = '0;
`ifdef PARAM_BUF_WSTRB_EN
        hw_strb = 4'hF; epu_wstrb = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (hcmd_ready !== 1'b0) begin errors++; $display("FAIL rst_hcmd_ready: got %b, required 0", hcmd_ready); end
        if (hw_ready !== 1'b0) begin errors++; $display("FAIL rst_hw_ready: got %b, required 0", hw_ready); end
        if (hr_valid !== 1'b0) begin errors++; $display("FAIL rst_hr_valid: got %b, required 0", hr_valid); end
        if (hr_last !== 1'b0) begin errors++; $display("FAIL rst_hr_last: got %b, required 0", hr_last); end
        if (epu_busy !== 1'b0) begin errors++; $display("FAIL rst_epu_busy: got %b, required 0", epu_busy); end
        if (hr_data !== 32'h0) begin errors++; $display("FAIL rst_hr_data: got %h, required 0", hr_data); end
        if (epu_rdata !== 32'h0) begin errors++; $display("FAIL rst_epu_rdata: got %h, required 0", epu_rdata); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL idle_hcmd_ready: got %b, required 1", hcmd_ready); end
        @(posedge clk); #1;
        // Preload both banks so the model never holds unknowns.
        for (int bk = 0; bk < NUM_BANKS; bk++) begin
            wq.delete();
            for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
            host_write(5'(bk * DEPTH), 8'(DEPTH - 1), 100, 1'b0, br, cu);
        end
    endtask

    task automatic test_write_burst();
        int br;
        int cu;
        wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        host_write(5'h12, 8'd3, 100, 1'b0, br, cu);
        checks += 2;
        if (br != 0) begin errors++; $display("FAIL wr_hcmd_busy: hcmd_ready high %0d cycles, required 0", br); end
        if (cu != 4) begin errors++; $display("FAIL wr_cycles: %0d cycles, required 4", cu); end
        @(negedge clk);
        checks += 2;
        if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL wr_done_ready: got %b, required 1", hcmd_ready); end
        if (hw_ready !== 1'b0) begin errors++; $display("FAIL wr_done_hw_ready: got %b, required 0", hw_ready); end
        @(posedge clk); #1;
        host_read(5'h10, 8'd15, 100);
        checks++;
        if (got_d.size() != DEPTH) begin
            errors++; $display("FAIL wr_readback_len: %0d beats, required %0d", got_d.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] exp;
                exp = (i >= 2 && i <= 5) ? 32'(32'hA0 + i - 2) : model_mem[16 + i];
                checks++;
                if (got_d[i] !== exp) begin
                    errors++; $display("FAIL wr_readback[%0d]: got %h, required %h", i, got_d[i], exp);
                end
            end
        end
    endtask

    task automatic test_read_wrap();
        host_read(5'h1E, 8'd3, 100);
        checks++;
        if (got_d.size() != 4) begin
            errors++; $display("FAIL wrap_len: %0d beats, required 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (got_d[i] !== model_mem[wrap_addr(5'h1E, i)]) begin
                    errors++; $display("FAIL wrap_data[%0d]: got %h, required %h", i, got_d[i],
                                       model_mem[wrap_addr(5'h1E, i)]);
                end
                if (got_l[i] !== (i == 3)) begin
                    errors++; $display("FAIL wrap_last[%0d]: got %b, required %b", i, got_l[i], i == 3);
                end
            end
        end
        host_read(5'h00, 8'd15, 100);
        checks++;
        if (got_d.size() != DEPTH) begin
            errors++; $display("FAIL bank0_len: %0d beats, required %0d", got_d.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (got_d[i] !== model_mem[i]) begin
                    errors++; $display("FAIL bank0[%0d]: got %h, required %h", i, got_d[i], model_mem[i]);
                end
            end
        end
    endtask

    task automatic test_read_backpressure();
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        host_read(5'h03, 8'd2, 100);
        checks += 2;
        if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls, required 0", stall_bad); end
        if (got_d.size() != 3) begin
            errors++; $display("FAIL bp_len: %0d beats, required 3", got_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (got_d[i] !== model_mem[3 + i]) begin
                    errors++; $display("FAIL bp_data[%0d]: got %h, required %h", i, got_d[i], model_mem[3 + i]);
                end
                if (got_l[i] !== (i == 2)) begin
                    errors++; $display("FAIL bp_last[%0d]: got %b, required %b", i, got_l[i], i == 2);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (hr_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat: hr_valid=%b, required 0", hr_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_epu_priority();
        logic [31:0] r7;
        r7 = $urandom;
        epu_start = 1'b1; hcmd_valid = 1'b1; hcmd_write = 1'b0; hcmd_addr = 5'd5; hcmd_len = 8'd0;
        @(negedge clk);
        checks++;
        if (hcmd_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b, required 0", hcmd_ready); end
        @(posedge clk); #1;
        epu_start = 1'b0;
        @(negedge clk);
        checks += 2;
        if (epu_busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b, required 1", epu_busy); end
        if (hcmd_ready !== 1'b0) begin errors++; $display("FAIL own_ready: got %b, required 0", hcmd_ready); end
        @(posedge clk); #1;
        epu_cs = 1'b1; epu_we = 1'b1; epu_addr = 5'd5; epu_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        model_mem[5] = 32'hDEADBEEF;
        epu_we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (epu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL epu_rd: got %h, required deadbeef", epu_rdata); end
        // A write issued alongside finish must still land.
        epu_finish = 1'b1; epu_we = 1'b1; epu_addr = 5'd7; epu_wdata = r7;
        @(posedge clk); #1;
        model_mem[7] = r7;
        epu_finish = 1'b0; epu_cs = 1'b0; epu_we = 1'b0;
        checks += 2;
        if (epu_busy !== 1'b0) begin errors++; $display("FAIL fin_busy: got %b, required 0", epu_busy); end
        if (epu_rdata !== 32'h0) begin errors++; $display("FAIL fin_rdata: got %h, required 0", epu_rdata); end
        @(negedge clk);
        checks++;
        if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL fin_ready: got %b, required 1", hcmd_ready); end
        @(posedge clk); #1;
        hcmd_valid = 1'b0; hr_ready = 1'b1;
        @(posedge clk); #1;
        checks += 3;
        if (hr_valid !== 1'b1) begin errors++; $display("FAIL post_rd_valid: got %b, required 1", hr_valid); end
        if (hr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL post_rd_data: got %h, required deadbeef", hr_data); end
        if (hr_last !== 1'b1) begin errors++; $display("FAIL post_rd_last: got %b, required 1", hr_last); end
        @(posedge clk); #1;
        hr_ready = 1'b0;
        host_read(5'd7, 8'd0, 100);
        checks++;
        if (got_d.size() != 1 || got_d[0] !== r7) begin
            errors++; $display("FAIL fin_write: got %0d beats first %h, required 1 beat %h",
                               got_d.size(), got_d.size() > 0 ? got_d[0] : 32'h0, r7);
        end
    endtask

    task automatic test_reset_mid_burst();
        hcmd_valid = 1'b1; hcmd_write = 1'b0; hcmd_addr = 5'h00; hcmd_len = 8'd3; hr_ready = 1'b1;
        @(posedge clk); #1;
        hcmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (hr_valid !== 1'b1 || hr_data !== model_mem[1]) begin
            errors++; $display("FAIL mid_beat2: valid=%b data=%h, required 1 %h", hr_valid, hr_data, model_mem[1]);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (hr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", hr_valid); end
        if (hr_last !== 1'b0) begin errors++; $display("FAIL mid_rst_last: got %b, required 0", hr_last); end
        rst = 1'b1; hr_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: hcmd_ready=%b, required 1", hcmd_ready); end
        if (hr_valid !== 1'b0) begin errors++; $display("FAIL mid_no_beat: hr_valid=%b, required 0", hr_valid); end
        @(posedge clk); #1;
        host_read(5'h00, 8'd3, 100);
        checks++;
        if (got_d.size() != 4) begin
            errors++; $display("FAIL mid_reread_len: %0d beats, required 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_d[i] !== model_mem[i]) begin
                    errors++; $display("FAIL mid_reread[%0d]: got %h, required %h", i, got_d[i], model_mem[i]);
                end
            end
        end
    endtask

`ifdef PARAM_BUF_WSTRB_EN
    task automatic test_strobe();
        epu_acquire();
        epu_cs = 1'b1; epu_we = 1'b1; epu_addr = 5'd9; epu_wdata = 32'h11223344; epu_wstrb = 4'hF;
        @(posedge clk); #1;
        epu_wdata = 32'hAABBCCDD; epu_wstrb = 4'b0101;
        @(posedge clk); #1;
        epu_we = 1'b0;
        @(posedge clk); #1;
        model_mem[9] = 32'h11BB33DD;
        checks++;
        if (epu_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL strb_rd: got %h, required 11bb33dd", epu_rdata); end
        epu_cs = 1'b0; epu_wstrb = 4'hF; epu_finish = 1'b1;
        @(posedge clk); #1;
        epu_finish = 1'b0;
    endtask
`endif

    task automatic test_random();
        int br;
        int cu;
        for (int it = 0; it < 30; it++) begin
            int op;
            logic [AW-1:0] a;
            logic [7:0] len;
            op = $urandom_range(2);
            a = 5'($urandom);
            len = 8'($urandom_range(40));
            if (op < 2) begin
                // Stray EPU traffic while not owning must be ignored.
                epu_cs = 1'b1; epu_we = 1'b1; epu_addr = 5'($urandom); epu_wdata = $urandom;
                if (op == 0) begin
                    wq.delete();
                    for (int i = 0; i <= int'(len); i++) wq.push_back($urandom);
                    host_write(a, len, $urandom_range(30, 100), 1'b1, br, cu);
                    checks++;
                    if (br != 0) begin errors++; $display("FAIL rnd_wr_busy: hcmd_ready high %0d cycles, required 0", br); end
                end else begin
                    host_read(a, len, $urandom_range(30, 100));
                    checks += 2;
                    if (stall_bad != 0) begin errors++; $display("FAIL rnd_stable: %0d unstable stalls, required 0", stall_bad); end
                    if (got_d.size() != int'(len) + 1) begin
                        errors++; $display("FAIL rnd_rd_len: %0d beats, required %0d", got_d.size(), len + 1);
                    end else begin
                        for (int i = 0; i <= int'(len); i++) begin
                            checks++;
                            if (got_d[i] !== model_mem[wrap_addr(a, i)] || got_l[i] !== (i == int'(len))) begin
                                errors++; $display("FAIL rnd_rd[%0d]: got %h last %b, required %h last %b", i,
                                                   got_d[i], got_l[i], model_mem[wrap_addr(a, i)], i == int'(len));
                            end
                        end
                    end
                end
                checks++;
                if (epu_rdata !== 32'h0) begin errors++; $display("FAIL rnd_rdata_idle: got %h, required 0", epu_rdata); end
                epu_cs = 1'b0; epu_we = 1'b0;
            end else begin
                epu_acquire();
                for (int j = 0; j < 8; j++) begin
                    logic [3:0] s;
                    epu_cs = ($urandom_range(3) != 0); epu_we = 1'($urandom);
                    epu_addr = 5'($urandom); epu_wdata = $urandom;
                    s = 4'hF;
`ifdef PARAM_BUF_WSTRB_EN
                    s = 4'($urandom);
                    epu_wstrb = s;
`endif
                    @(posedge clk); #1;
                    if (epu_cs && epu_we) model_mem[epu_addr] = merge(model_mem[epu_addr], epu_wdata, s);
                    if (epu_cs && !epu_we) begin
                        checks++;
                        if (epu_rdata !== model_mem[epu_addr]) begin
                            errors++; $display("FAIL rnd_epu_rd[%0d]: got %h, required %h", epu_addr,
                                               epu_rdata, model_mem[epu_addr]);
                        end
                    end
                end
                epu_cs = 1'b0; epu_finish = 1'b1;
                @(posedge clk); #1;
                epu_finish = 1'b0;
                checks++;
                if (epu_busy !== 1'b0) begin errors++; $display("FAIL rnd_fin_busy: got %b, required 0", epu_busy); end
            end
        end
        for (int bk = 0; bk < NUM_BANKS; bk++) begin
            host_read(5'(bk * DEPTH), 8'(DEPTH - 1), 100);
            checks++;
            if (got_d.size() != DEPTH) begin
                errors++; $display("FAIL final_len: %0d beats, required %0d", got_d.size(), DEPTH);
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    checks++;
                    if (got_d[i] !== model_mem[bk * DEPTH + i]) begin
                        errors++; $display("FAIL final[%0d]: got %h, required %h", bk * DEPTH + i,
                                           got_d[i], model_mem[bk * DEPTH + i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_read_backpressure();
        test_epu_priority();
        test_reset_mid_burst();
`ifdef PARAM_BUF_WSTRB_EN
        test_strobe();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
